// File: rtl/arb_mux_stream_if.sv
// arb_mux_stream_if
//   Handshake bundle for the arb_mux_stream N:1 arbitrated stream mux.
//   Parameters: NUM_CH (channel count), WIDTH (data bits per channel).
//   Signals:
//     in_valid  [NUM_CH]        per-channel beat valid      (source -> mux)
//     in_ready  [NUM_CH]        per-channel beat accepted   (mux -> source)
//     in_data   [NUM_CH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//     in_last   [NUM_CH]        per-channel end-of-packet
//     out_valid                 output register holds a beat
//     out_ready                 sink accepts the beat
//     out_data  [WIDTH]         registered data
//     out_last                  registered last flag
//     out_ch    [CH_W]          channel that supplied the current beat
//   Modports: slave = the mux, master = the sources/sink side.
interface arb_mux_stream_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [CH_W-1:0]         out_ch;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );
endinterface

// File: rtl/arb_mux_stream.sv
// arb_mux_stream
//   NUM_CH:1 stream multiplexer with round-robin arbitration, valid/ready
//   handshake on every channel and one registered output stage.
//   Throughput is one beat per cycle; latency from acceptance to out_* is
//   one cycle.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - arb_mux_stream_if.slave (per-channel inputs, registered output)
//   Optional feature (macro ARB_MUX_STREAM_PKT_LOCK_EN):
//     when defined, a channel that starts a packet (beat with in_last=0)
//     keeps the grant until it transfers its in_last=1 beat, so packets
//     from different channels are never interleaved. Ports are identical
//     either way.
module arb_mux_stream #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    arb_mux_stream_if.slave   bus
);
    localparam int CH_W = $clog2(NUM_CH);

    // Round-robin pointer: last channel granted; search starts at ptr+1.
    logic [CH_W-1:0]  ptr;

    // Output register stage.
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             last_p1;
    logic [CH_W-1:0]  ch_p1;

    logic [WIDTH-1:0] ch_data [NUM_CH];
    logic             rr_vld;
    logic [CH_W-1:0]  rr_grant;
    logic             req;
    logic [CH_W-1:0]  grant;
    logic             load;
    logic             xfer;

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                 input int off);
        return CH_W'((int'(base) + off) % NUM_CH);
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // Stage 0: combinational round-robin arbitration over in_valid.
    always_comb begin
        rr_vld   = 1'b0;
        rr_grant = ptr;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!rr_vld && bus.in_valid[wrap_idx(ptr, k)]) begin
                rr_vld   = 1'b1;
                rr_grant = wrap_idx(ptr, k);
            end
        end
    end

`ifdef ARB_MUX_STREAM_PKT_LOCK_EN
    logic            locked;
    logic [CH_W-1:0] lock_ch;

    // While locked the arbiter is bypassed; the locked channel keeps the
    // grant even when it has nothing to send, stalling the others.
    always_comb begin
        grant = locked ? lock_ch : rr_grant;
        req   = locked ? bus.in_valid[lock_ch] : rr_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            if (!bus.in_last[grant]) begin
                locked  <= 1'b1;
                lock_ch <= grant;
            end else begin
                locked  <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        grant = rr_grant;
        req   = rr_vld;
    end
`endif

    // The output register can take a beat when empty or draining this cycle.
    assign load = !vld_p1 || bus.out_ready;
    // rst gates the handshake so no source sees in_ready during reset.
    assign xfer = !rst && load && req;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    // Stage 1: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            ch_p1   <= '0;
            ptr     <= CH_W'(NUM_CH - 1);
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= ch_data[grant];
            last_p1 <= bus.in_last[grant];
            ch_p1   <= grant;
            ptr     <= grant;
        end else if (load) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_ch    = ch_p1;
endmodule

// File: tb/tb_arb_mux_stream.sv
module tb_arb_mux_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    arb_mux_stream_if #(.NUM_CH(4), .WIDTH(8)) bus ();

    arb_mux_stream #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [1:0] ch;
    } beat_t;

    beat_t sb[$];
    beat_t mexp;
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        else
            passes++;
    endtask

    // Monitor: every beat presented on the output must match the queue head;
    // it is popped when the sink takes it.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {bus.out_data, bus.out_last, bus.out_ch}, 32'hFFFF_FFFF);
            end else begin
                mexp = sb[0];
                chk("out_data", bus.out_data, mexp.d);
                chk("out_last", bus.out_last, mexp.l);
                chk("out_ch",   bus.out_ch,   mexp.ch);
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    // One directed cycle: drive inputs, check in_ready / out_valid, and queue
    // the beat the granted channel hands over.
    task automatic vec(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic ordy,
                       input logic [3:0] rdy, input logic ov);
        beat_t b;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge clk);
        chk("in_ready",  bus.in_ready,  rdy);
        chk("out_valid", bus.out_valid, ov);
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                b.d  = d[i*8 +: 8];
                b.l  = l[i];
                b.ch = 2'(i);
                sb.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.in_valid  = 4'hF;
        bus.in_last   = 4'hF;
        bus.in_data   = 32'hA3A2A1A0;
        bus.out_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 4'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready2",  bus.in_ready,  4'h0);
        chk("rst_out_valid",  bus.out_valid, 1'b0);
        chk("rst_out_data",   bus.out_data,  8'h00);
        chk("rst_out_last",   bus.out_last,  1'b0);
        chk("rst_out_ch",     bus.out_ch,    2'd0);
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset();

        // Round-robin with all channels valid: 0,1,2,3,0,1,2,3, no bubbles.
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 0);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0010, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0100, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b1000, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0010, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0100, 1);
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b1000, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);

        // Backpressure: 0x55 from channel 2 held for 3 stalled cycles.
        vec(4'h4, 4'hF, 32'h00550000, 1, 4'b0100, 0);
        vec(4'h1, 4'hF, 32'h00000077, 0, 4'b0000, 1);
        vec(4'h1, 4'hF, 32'h00000077, 0, 4'b0000, 1);
        vec(4'h1, 4'hF, 32'h00000077, 0, 4'b0000, 1);
        vec(4'h1, 4'hF, 32'h00000077, 1, 4'b0001, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);

        // Sparse requests: channel 3 then channel 1.
        vec(4'h8, 4'hF, 32'h3C000000, 1, 4'b1000, 0);
        vec(4'h2, 4'hF, 32'h00001E00, 1, 4'b0010, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 0);

        // Park the pointer on channel 0 so channel 1 wins next.
        vec(4'h1, 4'hF, 32'h00000001, 1, 4'b0001, 0);

        // Channel 1 sends 0x10,0x11,0x12 (last on the third) against 0/2/3.
`ifdef ARB_MUX_STREAM_PKT_LOCK_EN
        vec(4'hF, 4'hD, 32'h3A2A100A, 1, 4'b0010, 1);
        vec(4'hF, 4'hD, 32'h3A2A110A, 1, 4'b0010, 1);
        vec(4'hD, 4'hD, 32'h3A2A110A, 1, 4'b0000, 1);
        vec(4'hF, 4'hF, 32'h3A2A120A, 1, 4'b0010, 0);
        vec(4'hD, 4'hF, 32'h3A2A120A, 1, 4'b0100, 1);
        vec(4'h9, 4'hF, 32'h3A2A120A, 1, 4'b1000, 1);
        vec(4'h1, 4'hF, 32'h3A2A120A, 1, 4'b0001, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 0);
`else
        vec(4'hF, 4'hD, 32'h3A2A100A, 1, 4'b0010, 1);
        vec(4'hF, 4'hD, 32'h3A2A110A, 1, 4'b0100, 1);
        vec(4'hD, 4'hD, 32'h3A2A110A, 1, 4'b1000, 1);
        vec(4'hF, 4'hD, 32'h3A2A110A, 1, 4'b0001, 1);
        vec(4'hF, 4'hD, 32'h3A2A110A, 1, 4'b0010, 1);
        vec(4'h2, 4'hF, 32'h3A2A120A, 1, 4'b0010, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 0);
`endif

        // Reset with a beat in the output register: beat discarded,
        // arbitration restarts at channel 0.
        vec(4'h4, 4'hF, 32'h00990000, 1, 4'b0100, 0);
        do_reset();
        vec(4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 0);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 1);
        vec(4'h0, 4'hF, 32'h00000000, 1, 4'b0000, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
